// File: rtl/rom_square_arb_if.sv
// Client and ROM side signals of the square-sprite ROM burst arbiter.
// The arbiter takes the slave view; the clients and ROM share the master view.
interface rom_square_arb_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [LEN_WIDTH-1:0]  len0;
    logic                  ack0;
    logic                  rvalid0;
    logic                  rlast0;

    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [LEN_WIDTH-1:0]  len1;
    logic                  ack1;
    logic                  rvalid1;
    logic                  rlast1;

    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_rdata;

    modport slave (
        input  req0, addr0, len0, req1, addr1, len1, rom_rdata,
        output ack0, rvalid0, rlast0, ack1, rvalid1, rlast1, rdata, busy, rom_addr
    );

    modport master (
        output req0, addr0, len0, req1, addr1, len1, rom_rdata,
        input  ack0, rvalid0, rlast0, ack1, rvalid1, rlast1, rdata, busy, rom_addr
    );
endinterface

// File: rtl/rom_square_arb.sv
// Round-robin burst read arbiter for the single-port square-sprite ROM.
// Two clients post {start address, length-1}; the winner gets one ROM address
// per cycle and its data comes back tagged with per-port valid/last strobes.
module rom_square_arb #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rom_square_arb_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  gnt;

    // Return tags travel RD_LATENCY stages to line up with ROM read data.
    logic [RD_LATENCY-1:0] issue_p;
    logic [RD_LATENCY-1:0] owner_p;
    logic [RD_LATENCY-1:0] last_p;

    // Control registers: state, burst counter, address, ownership and ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;   // port 0 wins the first tie
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    // Grant selection in IDLE and address stepping in BURST.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        gnt          = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that did not own the last burst wins.
                    gnt          = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;
                    owner_d      = gnt;
                    last_owner_d = gnt;
                    cnt_d        = gnt ? bus.len1 : bus.len0;
                    rom_addr_d   = gnt ? bus.addr1 : bus.addr0;
                    ack0_d       = ~gnt;
                    ack1_d       = gnt;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (cnt_q != '0) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag pipeline: one entry per cycle, issue marks a real ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_p <= '0;
            owner_p <= '0;
            last_p  <= '0;
        end else begin
            issue_p[0] <= (state_q == BURST);
            owner_p[0] <= owner_q;
            last_p[0]  <= (state_q == BURST) && (cnt_q == '0);
            for (int i = 1; i < RD_LATENCY; i++) begin
                issue_p[i] <= issue_p[i-1];
                owner_p[i] <= owner_p[i-1];
                last_p[i]  <= last_p[i-1];
            end
        end
    end

    // Output decode from the pipeline tail; data passes straight through.
    always_comb begin
        bus.ack0     = ack0_q;
        bus.ack1     = ack1_q;
        bus.rvalid0  = issue_p[RD_LATENCY-1] && !owner_p[RD_LATENCY-1];
        bus.rvalid1  = issue_p[RD_LATENCY-1] &&  owner_p[RD_LATENCY-1];
        bus.rlast0   = bus.rvalid0 && last_p[RD_LATENCY-1];
        bus.rlast1   = bus.rvalid1 && last_p[RD_LATENCY-1];
        bus.rdata    = bus.rom_rdata;
        bus.busy     = (state_q == BURST) || (|issue_p);
        bus.rom_addr = rom_addr_q;
    end
endmodule

// File: tb/tb_rom_square_arb.sv
// Directed bench for rom_square_arb. Two instances share one stimulus:
// dut_a with a 1-cycle ROM, dut_b with a 2-cycle ROM. ROM[i] = i ^ 8'h5A.
module tb_rom_square_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] addr0, addr1;
    logic [3:0] len0, len1;
    logic [7:0] rom_b_q;

    int n_vec  = 0;
    int n_miss = 0;
    int cur    = 0;

    always #5 clk = ~clk;

    rom_square_arb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(4)) bus_a ();
    rom_square_arb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(4)) bus_b ();

    assign bus_a.req0 = req0;  assign bus_b.req0 = req0;
    assign bus_a.addr0 = addr0; assign bus_b.addr0 = addr0;
    assign bus_a.len0 = len0;  assign bus_b.len0 = len0;
    assign bus_a.req1 = req1;  assign bus_b.req1 = req1;
    assign bus_a.addr1 = addr1; assign bus_b.addr1 = addr1;
    assign bus_a.len1 = len1;  assign bus_b.len1 = len1;

    rom_square_arb #(.RD_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    rom_square_arb #(.RD_LATENCY(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // ROM models: registered read, plus an output register for dut_b.
    always @(posedge clk) begin
        bus_a.rom_rdata <= rom_f(bus_a.rom_addr);
        rom_b_q         <= rom_f(bus_b.rom_addr);
        bus_b.rom_rdata <= rom_b_q;
    end

    // f  = {ack0, ack1, rvalid0, rvalid1, rlast0, rlast1, busy} of dut_a
    // fb = {rvalid0, rlast0, busy} of dut_b, checked only when cb is set
    typedef struct {
        logic       rb;
        logic       r0; logic [7:0] a0; logic [3:0] l0;
        logic       r1; logic [7:0] a1; logic [3:0] l1;
        logic [6:0] f;  logic [7:0] rd; logic [7:0] ra;
        logic       cb; logic [2:0] fb; logic [7:0] rdb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rb,
                       input logic r0, input logic [7:0] a0, input logic [3:0] l0,
                       input logic r1, input logic [7:0] a1, input logic [3:0] l1,
                       input logic [6:0] f, input logic [7:0] rd, input logic [7:0] ra,
                       input logic cb, input logic [2:0] fb, input logic [7:0] rdb);
        vec_t v;
        v.rb = rb; v.r0 = r0; v.a0 = a0; v.l0 = l0; v.r1 = r1; v.a1 = a1; v.l1 = l1;
        v.f = f; v.rd = rd; v.ra = ra; v.cb = cb; v.fb = fb; v.rdb = rdb;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        if (act !== exp) begin
            $display("FAIL vec %0d %s: got %b expected %b", cur, nm, act, exp);
            n_miss++;
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            $display("FAIL vec %0d %s: got %h expected %h", cur, nm, act, exp);
            n_miss++;
        end
    endtask

    task automatic check_a(input logic [6:0] f, input logic [7:0] rd, input logic [7:0] ra);
        n_vec++;
        chk1("a.ack0", bus_a.ack0, f[6]);
        chk1("a.ack1", bus_a.ack1, f[5]);
        chk1("a.rvalid0", bus_a.rvalid0, f[4]);
        chk1("a.rvalid1", bus_a.rvalid1, f[3]);
        chk1("a.rlast0", bus_a.rlast0, f[2]);
        chk1("a.rlast1", bus_a.rlast1, f[1]);
        chk1("a.busy", bus_a.busy, f[0]);
        chk8("a.rom_addr", bus_a.rom_addr, ra);
        chk1("a.rvalid_excl", bus_a.rvalid0 & bus_a.rvalid1, 1'b0);
        if (f[4] | f[3]) chk8("a.rdata", bus_a.rdata, rd);
    endtask

    task automatic check_b(input logic [2:0] fb, input logic [7:0] rdb);
        n_vec++;
        chk1("b.rvalid0", bus_b.rvalid0, fb[2]);
        chk1("b.rlast0", bus_b.rlast0, fb[1]);
        chk1("b.busy", bus_b.busy, fb[0]);
        chk1("b.rvalid1", bus_b.rvalid1, 1'b0);
        if (fb[2]) chk8("b.rdata", bus_b.rdata, rdb);
    endtask

    task automatic check_zero();
        check_a(7'b0000000, 8'h00, 8'h00);
        check_b(3'b000, 8'h00);
        chk1("b.ack0", bus_b.ack0, 1'b0);
        chk1("b.ack1", bus_b.ack1, 1'b0);
        chk8("b.rom_addr", bus_b.rom_addr, 8'h00);
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; addr0 = 8'h00; len0 = 4'h0;
        req1 = 1'b0; addr1 = 8'h00; len1 = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic stray;

        // Scenario 1: port 0, addr 0x10, len 3 (both ROM latencies)
        add(0, 1,8'h10,3, 0,8'h00,0, 7'b1000001, 8'h00, 8'h10, 1, 3'b001, 8'h00);
        add(0, 1,8'h10,3, 0,8'h00,0, 7'b0010001, 8'h4A, 8'h11, 1, 3'b001, 8'h00);
        add(0, 0,8'h10,3, 0,8'h00,0, 7'b0010001, 8'h4B, 8'h12, 1, 3'b101, 8'h4A);
        add(0, 0,8'h10,3, 0,8'h00,0, 7'b0010001, 8'h48, 8'h13, 1, 3'b101, 8'h4B);
        add(0, 0,8'h10,3, 0,8'h00,0, 7'b0010101, 8'h49, 8'h13, 1, 3'b101, 8'h48);
        add(0, 0,8'h10,3, 0,8'h00,0, 7'b0000000, 8'h00, 8'h13, 1, 3'b111, 8'h49);
        add(0, 0,8'h10,3, 0,8'h00,0, 7'b0000000, 8'h00, 8'h13, 1, 3'b000, 8'h00);
        // Scenario 3: port 1 wraps at 0xFF; addr/len change after ack ignored
        add(0, 0,8'h00,0, 1,8'hFE,3, 7'b0100001, 8'h00, 8'hFE, 0, 3'b000, 8'h00);
        add(0, 0,8'h00,0, 1,8'h77,0, 7'b0001001, 8'hA4, 8'hFF, 0, 3'b000, 8'h00);
        add(0, 0,8'h00,0, 0,8'h77,0, 7'b0001001, 8'hA5, 8'h00, 0, 3'b000, 8'h00);
        add(0, 0,8'h00,0, 0,8'h77,0, 7'b0001001, 8'h5A, 8'h01, 0, 3'b000, 8'h00);
        add(0, 0,8'h00,0, 0,8'h77,0, 7'b0001011, 8'h5B, 8'h01, 0, 3'b000, 8'h00);
        add(0, 0,8'h00,0, 0,8'h77,0, 7'b0000000, 8'h00, 8'h01, 0, 3'b000, 8'h00);
        // Scenario 6: req1 raised during a port 0 burst and dropped before IDLE
        add(0, 1,8'h10,3, 0,8'h80,0, 7'b1000001, 8'h00, 8'h10, 0, 3'b000, 8'h00);
        add(0, 0,8'h10,3, 1,8'h80,0, 7'b0010001, 8'h4A, 8'h11, 0, 3'b000, 8'h00);
        add(0, 0,8'h10,3, 1,8'h80,0, 7'b0010001, 8'h4B, 8'h12, 0, 3'b000, 8'h00);
        add(0, 0,8'h10,3, 1,8'h80,0, 7'b0010001, 8'h48, 8'h13, 0, 3'b000, 8'h00);
        add(0, 0,8'h10,3, 0,8'h80,0, 7'b0010101, 8'h49, 8'h13, 0, 3'b000, 8'h00);
        add(0, 0,8'h10,3, 0,8'h80,0, 7'b0000000, 8'h00, 8'h13, 0, 3'b000, 8'h00);
        add(0, 0,8'h10,3, 0,8'h80,0, 7'b0000000, 8'h00, 8'h13, 0, 3'b000, 8'h00);
        // Scenario 2: simultaneous single-word requests after reset alternate 0,1,0,1
        add(1, 1,8'h20,0, 1,8'h30,0, 7'b1000001, 8'h00, 8'h20, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b0010101, 8'h7A, 8'h20, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b0100001, 8'h00, 8'h30, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b0001011, 8'h6A, 8'h30, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b1000001, 8'h00, 8'h20, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b0010101, 8'h7A, 8'h20, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b0100001, 8'h00, 8'h30, 0, 3'b000, 8'h00);
        add(0, 1,8'h20,0, 1,8'h30,0, 7'b0001011, 8'h6A, 8'h30, 0, 3'b000, 8'h00);
        add(0, 0,8'h20,0, 0,8'h30,0, 7'b0000000, 8'h00, 8'h30, 0, 3'b000, 8'h00);

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        cur = -1;
        check_zero();
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            if (vecs[i].rb) do_reset();
            else @(negedge clk);
            req0 = vecs[i].r0; addr0 = vecs[i].a0; len0 = vecs[i].l0;
            req1 = vecs[i].r1; addr1 = vecs[i].a1; len1 = vecs[i].l1;
            @(posedge clk);
            #1;
            check_a(vecs[i].f, vecs[i].rd, vecs[i].ra);
            if (vecs[i].cb) check_b(vecs[i].fb, vecs[i].rdb);
        end

        // Scenario 4: reset during the 3rd beat of a 16-word burst
        cur = 100;
        do_reset();
        req0 = 1'b1; addr0 = 8'h40; len0 = 4'hF;
        @(posedge clk); #1;
        check_a(7'b1000001, 8'h00, 8'h40);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        cur = 101;
        check_a(7'b0010001, 8'h1A, 8'h41);
        @(posedge clk); #1;
        cur = 102;
        check_a(7'b0010001, 8'h1B, 8'h42);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cur = 103;
        check_zero();
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            stray |= bus_a.rvalid0 | bus_a.rvalid1 | bus_a.rlast0 | bus_a.rlast1 | bus_a.busy
                   | bus_b.rvalid0 | bus_b.rvalid1 | bus_b.rlast0 | bus_b.rlast1 | bus_b.busy
                   | bus_a.ack0 | bus_a.ack1;
        end
        cur = 104;
        n_vec++;
        chk1("post_reset_residue", stray, 1'b0);
        @(negedge clk);
        req0 = 1'b1; addr0 = 8'h05; len0 = 4'h0;
        @(posedge clk); #1;
        cur = 105;
        check_a(7'b1000001, 8'h00, 8'h05);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        cur = 106;
        check_a(7'b0010101, 8'h5F, 8'h05);
        @(posedge clk); #1;
        cur = 107;
        check_a(7'b0000000, 8'h00, 8'h05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
